// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types and codes for the ATM session controller
package atm_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_LOOKUP,
    S_PIN_WAIT,
    S_MENU,
    S_AMOUNT,
    S_CHECK,
    S_CONFIRM,
    S_UPDATE,
    S_MORE,
    S_EJECT
  } state_t;

  localparam logic [1:0] OP_DEPOSIT  = 2'd0;
  localparam logic [1:0] OP_WITHDRAW = 2'd1;
  localparam logic [1:0] OP_BALANCE  = 2'd2;
  localparam logic [1:0] OP_END      = 2'd3;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_SCAN    = 3'd1;
  localparam logic [2:0] ERR_LOCKED  = 3'd2;
  localparam logic [2:0] ERR_BAD_PIN = 3'd3;
  localparam logic [2:0] ERR_FUNDS   = 3'd4;
  localparam logic [2:0] ERR_LIMIT   = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT = 3'd6;
  localparam logic [2:0] ERR_TXN_CAP = 3'd7;

  // States where the session waits on the user and the idle timer runs
  function automatic logic is_wait_state(input state_t s);
    return (s inside {S_SCAN, S_PIN_WAIT, S_MENU, S_AMOUNT, S_CONFIRM, S_MORE});
  endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// rtl/atm_session_ctrl_if.sv - front-end and account-memory signals of the session controller
interface atm_session_ctrl_if #(
  parameter int AMT_W = 16
);
  logic             card_inserted;
  logic             card_scanned;
  logic             acct_locked;
  logic             pin_valid;
  logic             pin_match;
  logic             op_valid;
  logic [1:0]       op_sel;
  logic             amt_valid;
  logic [AMT_W-1:0] amt_in;
  logic [AMT_W-1:0] bal_in;
  logic             user_confirm;
  logic             user_cancel;
  logic             more_txn;
  logic             upd_ack;
  logic             upd_req;
  logic             upd_op;
  logic [AMT_W-1:0] upd_amt;
  logic             lock_acc;
  logic [3:0]       pin_tries_left;
  logic             session_active;
  logic             show_balance;
  logic             txn_done;
  logic             err_valid;
  logic [2:0]       err_code;
  logic             eject;

  // Controller side
  modport master (
    input  card_inserted, card_scanned, acct_locked, pin_valid, pin_match,
           op_valid, op_sel, amt_valid, amt_in, bal_in, user_confirm,
           user_cancel, more_txn, upd_ack,
    output upd_req, upd_op, upd_amt, lock_acc, pin_tries_left, session_active,
           show_balance, txn_done, err_valid, err_code, eject
  );

  // Front end / account memory side
  modport slave (
    output card_inserted, card_scanned, acct_locked, pin_valid, pin_match,
           op_valid, op_sel, amt_valid, amt_in, bal_in, user_confirm,
           user_cancel, more_txn, upd_ack,
    input  upd_req, upd_op, upd_amt, lock_acc, pin_tries_left, session_active,
           show_balance, txn_done, err_valid, err_code, eject
  );
endinterface

// File: rtl/atm_timeout_cnt.sv
// rtl/atm_timeout_cnt.sv - idle-cycle counter with synchronous clear and expiry flag
module atm_timeout_cnt #(
  parameter int LIMIT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);
  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_en && (r_cnt == LIMIT_C);

  // Count idle cycles; saturate at the limit, restart on clear or outside wait states
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en) begin
      r_cnt <= '0;
    end else if (!o_expire) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM session sequencer: card, PIN, transaction loop, memory update
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int MAX_PIN_TRIES  = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AMT_W          = 16,
  parameter int MAX_TXN        = 8,
  parameter int WDRAW_LIMIT    = 1000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  atm_session_ctrl_if.master bus
);
  localparam logic [3:0]     TRIES_INIT = 4'(MAX_PIN_TRIES);
  localparam logic [7:0]     TXN_CAP    = 8'(MAX_TXN);
  localparam logic [AMT_W:0] LIMIT_EXT  = (AMT_W + 1)'(WDRAW_LIMIT);

  state_t           r_state, w_next;
  logic [3:0]       r_tries, w_tries;
  logic [7:0]       r_txn_cnt, w_txn_cnt;
  logic             r_session, w_session;
  logic [AMT_W-1:0] r_amt, w_amt;
  logic             r_wd, w_wd;
  logic [2:0]       r_err_code, w_err_code;
  logic             r_upd_req, r_lock, r_show, r_txn_done, r_err_valid, r_eject;
  logic             w_lock, w_show, w_txn_done, w_err, w_accept;
  logic             w_expire, w_clr, w_tmo_en;
  logic [AMT_W:0]   w_amt_ext, w_sum;

  assign w_amt_ext = {1'b0, r_amt};
  assign w_sum     = w_amt_ext + {1'b0, bus.bal_in};
  assign w_tmo_en  = is_wait_state(r_state);
  assign w_clr     = (w_next != r_state) || w_accept;

  atm_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_tmo_en),
    .i_clr    (w_clr),
    .o_expire (w_expire)
  );

  // Next-state, next-output and datapath-update decisions
  always_comb begin
    w_next     = r_state;
    w_tries    = r_tries;
    w_txn_cnt  = r_txn_cnt;
    w_session  = r_session;
    w_amt      = r_amt;
    w_wd       = r_wd;
    w_err      = 1'b0;
    w_err_code = ERR_NONE;
    w_lock     = 1'b0;
    w_show     = 1'b0;
    w_txn_done = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: if (bus.card_inserted) w_next = S_SCAN;
      S_SCAN: begin
        if (bus.card_scanned) begin
          w_accept = 1'b1;
          w_next   = S_LOOKUP;
        end else if (w_expire) begin
          w_err = 1'b1; w_err_code = ERR_SCAN; w_next = S_EJECT;
        end
      end
      S_LOOKUP: begin
        if (bus.acct_locked) begin
          w_err = 1'b1; w_err_code = ERR_LOCKED; w_next = S_EJECT;
        end else begin
          w_tries = TRIES_INIT;
          w_next  = S_PIN_WAIT;
        end
      end
      S_PIN_WAIT: begin
        if (bus.pin_valid) begin
          w_accept = 1'b1;
          if (bus.pin_match) begin
            w_session = 1'b1; w_txn_cnt = '0; w_next = S_MENU;
          end else if (r_tries <= 4'd1) begin
            w_tries = '0; w_lock = 1'b1;
            w_err = 1'b1; w_err_code = ERR_BAD_PIN; w_next = S_EJECT;
          end else begin
            w_tries = r_tries - 4'd1;
          end
        end else if (w_expire) begin
          w_err = 1'b1; w_err_code = ERR_TIMEOUT; w_next = S_EJECT;
        end
      end
      S_MENU: begin
        if (bus.op_valid) begin
          w_accept = 1'b1;
          case (bus.op_sel)
            OP_DEPOSIT:  begin w_wd = 1'b0; w_next = S_AMOUNT; end
            OP_WITHDRAW: begin w_wd = 1'b1; w_next = S_AMOUNT; end
            OP_BALANCE:  begin w_show = 1'b1; w_next = S_MORE; end
            default:     w_next = S_EJECT;
          endcase
        end else if (w_expire) begin
          w_err = 1'b1; w_err_code = ERR_TIMEOUT; w_next = S_EJECT;
        end
      end
      S_AMOUNT: begin
        if (bus.amt_valid) begin
          w_accept = 1'b1;
          if (bus.amt_in == '0) begin
            w_next = S_MENU;
          end else begin
            w_amt  = bus.amt_in;
            w_next = S_CHECK;
          end
        end else if (w_expire) begin
          w_err = 1'b1; w_err_code = ERR_TIMEOUT; w_next = S_EJECT;
        end
      end
      S_CHECK: begin
        w_next = S_CONFIRM;
        if (r_wd) begin
          if (w_amt_ext > LIMIT_EXT) begin
            w_err = 1'b1; w_err_code = ERR_LIMIT; w_next = S_MORE;
          end else if (r_amt > bus.bal_in) begin
            w_err = 1'b1; w_err_code = ERR_FUNDS; w_next = S_MORE;
          end
        end else if (w_sum[AMT_W]) begin
          w_err = 1'b1; w_err_code = ERR_LIMIT; w_next = S_MORE;
        end
      end
      S_CONFIRM: begin
        if (bus.user_cancel) begin
          w_accept = 1'b1; w_next = S_MENU;
        end else if (bus.user_confirm) begin
          w_accept = 1'b1; w_next = S_UPDATE;
        end else if (w_expire) begin
          w_err = 1'b1; w_err_code = ERR_TIMEOUT; w_next = S_EJECT;
        end
      end
      S_UPDATE: begin
        if (bus.upd_ack) begin
          w_txn_done = 1'b1;
          w_txn_cnt  = r_txn_cnt + 8'd1;
          w_next     = S_MORE;
        end
      end
      S_MORE: begin
        if (r_txn_cnt == TXN_CAP) begin
          w_err = 1'b1; w_err_code = ERR_TXN_CAP; w_next = S_EJECT;
        end else if (bus.more_txn) begin
          w_next = S_MENU;
        end else begin
          w_next = S_EJECT;
        end
      end
      S_EJECT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_next == S_EJECT) w_session = 1'b0;
  end

  // State and registered outputs; pulses land the cycle after their decision
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_tries     <= TRIES_INIT;
      r_txn_cnt   <= '0;
      r_session   <= 1'b0;
      r_amt       <= '0;
      r_wd        <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_upd_req   <= 1'b0;
      r_lock      <= 1'b0;
      r_show      <= 1'b0;
      r_txn_done  <= 1'b0;
      r_err_valid <= 1'b0;
      r_eject     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_tries     <= w_tries;
      r_txn_cnt   <= w_txn_cnt;
      r_session   <= w_session;
      r_amt       <= w_amt;
      r_wd        <= w_wd;
      r_upd_req   <= (w_next == S_UPDATE);
      r_lock      <= w_lock;
      r_show      <= w_show;
      r_txn_done  <= w_txn_done;
      r_err_valid <= w_err;
      r_eject     <= (w_next == S_EJECT);
      if (w_err) r_err_code <= w_err_code;
    end
  end

  assign bus.upd_req        = r_upd_req;
  assign bus.upd_op         = r_wd;
  assign bus.upd_amt        = r_amt;
  assign bus.lock_acc       = r_lock;
  assign bus.pin_tries_left = r_tries;
  assign bus.session_active = r_session;
  assign bus.show_balance   = r_show;
  assign bus.txn_done       = r_txn_done;
  assign bus.err_valid      = r_err_valid;
  assign bus.err_code       = r_err_code;
  assign bus.eject          = r_eject;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb/tb_atm_session_ctrl.sv - directed self-checking bench for atm_session_ctrl
module tb_atm_session_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  atm_session_ctrl_if #(.AMT_W(16)) bus ();

  atm_session_ctrl #(
    .MAX_PIN_TRIES (3),
    .TIMEOUT_CYCLES(16),
    .AMT_W         (16),
    .MAX_TXN       (2),
    .WDRAW_LIMIT   (1000)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.card_inserted = 0; bus.card_scanned = 0; bus.acct_locked = 0;
    bus.pin_valid = 0; bus.pin_match = 0; bus.op_valid = 0; bus.op_sel = 0;
    bus.amt_valid = 0; bus.amt_in = 0; bus.bal_in = 0; bus.user_confirm = 0;
    bus.user_cancel = 0; bus.more_txn = 0; bus.upd_ack = 0;
  endtask

  // From IDLE: ends in the first PIN_WAIT cycle
  task automatic to_pin_wait;
    bus.card_inserted = 1; tick; bus.card_inserted = 0;
    bus.card_scanned = 1; tick; bus.card_scanned = 0;
    tick;
  endtask

  // From IDLE: ends in the first MENU cycle
  task automatic to_menu;
    to_pin_wait;
    bus.pin_valid = 1; bus.pin_match = 1; tick;
    bus.pin_valid = 0; bus.pin_match = 0;
  endtask

  // From MENU: ends in the cycle after CHECK (CONFIRM or MORE)
  task automatic enter_amount(input logic [1:0] op, input logic [15:0] amt, input logic [15:0] bal);
    bus.op_valid = 1; bus.op_sel = op; tick; bus.op_valid = 0;
    bus.amt_valid = 1; bus.amt_in = amt; bus.bal_in = bal; tick; bus.amt_valid = 0;
    tick;
  endtask

  initial begin
    clear_inputs;
    rst = 1;
    tick; tick;
    chk("rst_upd_req", bus.upd_req, 0);
    chk("rst_tries", bus.pin_tries_left, 3);
    chk("rst_session", bus.session_active, 0);
    chk("rst_err_valid", bus.err_valid, 0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_eject", bus.eject, 0);
    rst = 0;
    tick;

    // Deposit 100 on balance 500, ack on the third request cycle
    to_menu;
    chk("t1_session", bus.session_active, 1);
    enter_amount(2'd0, 16'd100, 16'd500);
    chk("t1_no_err", bus.err_valid, 0);
    bus.user_confirm = 1; tick; bus.user_confirm = 0;
    chk("t1_upd_op", bus.upd_op, 0);
    chk("t1_upd_amt", bus.upd_amt, 100);
    for (int i = 0; i < 3; i++) begin
      chk("t1_req_held", bus.upd_req, 1);
      if (i == 2) bus.upd_ack = 1;
      tick;
    end
    bus.upd_ack = 0;
    chk("t1_req_drop", bus.upd_req, 0);
    chk("t1_txn_done", bus.txn_done, 1);
    tick;
    chk("t1_eject", bus.eject, 1);
    chk("t1_session_off", bus.session_active, 0);
    tick;
    chk("t1_eject_pulse", bus.eject, 0);

    // Locked account
    bus.card_inserted = 1; tick; bus.card_inserted = 0;
    bus.card_scanned = 1; tick; bus.card_scanned = 0;
    bus.acct_locked = 1; tick; bus.acct_locked = 0;
    chk("t2_locked_err", bus.err_valid, 1);
    chk("t2_locked_code", bus.err_code, 2);
    chk("t2_locked_eject", bus.eject, 1);
    tick;

    // Three wrong PINs
    to_pin_wait;
    chk("t2_tries3", bus.pin_tries_left, 3);
    for (int i = 0; i < 2; i++) begin
      bus.pin_valid = 1; tick; bus.pin_valid = 0;
      chk("t2_tries_dec", bus.pin_tries_left, 32'(2 - i));
      chk("t2_no_lock", bus.lock_acc, 0);
    end
    bus.pin_valid = 1; tick; bus.pin_valid = 0;
    chk("t2_tries0", bus.pin_tries_left, 0);
    chk("t2_lock", bus.lock_acc, 1);
    chk("t2_err_code", bus.err_code, 3);
    chk("t2_eject", bus.eject, 1);
    chk("t2_no_session", bus.session_active, 0);
    tick;
    chk("t2_lock_pulse", bus.lock_acc, 0);

    // Withdraw checks, limit boundary, overflow, zero amount, balance
    to_menu;
    enter_amount(2'd1, 16'd600, 16'd500);
    chk("t3_funds_err", bus.err_code, 4);
    chk("t3_funds_valid", bus.err_valid, 1);
    chk("t3_funds_noreq", bus.upd_req, 0);
    bus.more_txn = 1; tick; bus.more_txn = 0;
    chk("t3_back_menu", bus.eject, 0);
    enter_amount(2'd1, 16'd1200, 16'd5000);
    chk("t3_limit_err", bus.err_code, 5);
    bus.more_txn = 1; tick; bus.more_txn = 0;
    enter_amount(2'd1, 16'd1200, 16'd500);
    chk("t3_both_err", bus.err_code, 5);
    bus.more_txn = 1; tick; bus.more_txn = 0;
    enter_amount(2'd1, 16'd1000, 16'd1000);
    chk("t3_boundary_ok", bus.err_valid, 0);
    bus.user_cancel = 1; tick; bus.user_cancel = 0;
    chk("t3_cancel_noreq", bus.upd_req, 0);
    enter_amount(2'd0, 16'd100, 16'd65500);
    chk("t3_ovf_valid", bus.err_valid, 1);
    chk("t3_ovf_code", bus.err_code, 5);
    bus.more_txn = 1; tick; bus.more_txn = 0;
    bus.op_valid = 1; bus.op_sel = 0; tick; bus.op_valid = 0;
    bus.amt_valid = 1; bus.amt_in = 0; tick; bus.amt_valid = 0;
    bus.op_valid = 1; bus.op_sel = 2; tick; bus.op_valid = 0;
    chk("t3_show_balance", bus.show_balance, 1);
    tick;
    chk("t3_show_pulse", bus.show_balance, 0);
    chk("t3_eject", bus.eject, 1);
    tick;

    // End-session op
    to_menu;
    bus.op_valid = 1; bus.op_sel = 3; tick; bus.op_valid = 0;
    chk("t3_end_eject", bus.eject, 1);
    tick;

    // Transaction cap and confirm+cancel together
    to_menu;
    enter_amount(2'd0, 16'd10, 16'd0);
    bus.user_confirm = 1; bus.user_cancel = 1; tick;
    bus.user_confirm = 0; bus.user_cancel = 0;
    chk("t4_cancel_wins", bus.upd_req, 0);
    for (int t = 0; t < 2; t++) begin
      enter_amount(2'd0, 16'd10, 16'd0);
      bus.user_confirm = 1; tick; bus.user_confirm = 0;
      chk("t4_req", bus.upd_req, 1);
      bus.upd_ack = 1; tick; bus.upd_ack = 0;
      chk("t4_done", bus.txn_done, 1);
      bus.more_txn = 1; tick; bus.more_txn = 0;
    end
    chk("t4_cap_valid", bus.err_valid, 1);
    chk("t4_cap_code", bus.err_code, 7);
    chk("t4_cap_eject", bus.eject, 1);
    tick;

    // MENU timeout
    to_menu;
    for (int i = 0; i < 16; i++) tick;
    chk("t5_not_yet", bus.err_valid, 0);
    tick;
    chk("t5_tmo_valid", bus.err_valid, 1);
    chk("t5_tmo_code", bus.err_code, 6);
    chk("t5_tmo_eject", bus.eject, 1);
    tick;

    // Accepted PIN pulse at cycle 15 restarts the count
    to_pin_wait;
    for (int i = 0; i < 15; i++) tick;
    bus.pin_valid = 1; tick; bus.pin_valid = 0;
    chk("t5_restart_tries", bus.pin_tries_left, 2);
    tick;
    chk("t5_restart_17", bus.err_valid, 0);
    for (int i = 0; i < 15; i++) tick;
    chk("t5_restart_32", bus.err_valid, 0);
    tick;
    chk("t5_restart_33", bus.err_valid, 1);
    chk("t5_restart_code", bus.err_code, 6);
    tick;

    // Asynchronous reset during UPDATE
    to_menu;
    enter_amount(2'd0, 16'd50, 16'd0);
    bus.user_confirm = 1; tick; bus.user_confirm = 0;
    chk("t6_req_before", bus.upd_req, 1);
    #1 rst = 1;
    #1;
    chk("t6_req_async", bus.upd_req, 0);
    chk("t6_tries", bus.pin_tries_left, 3);
    chk("t6_session", bus.session_active, 0);
    tick;
    chk("t6_no_eject", bus.eject, 0);
    rst = 0;
    tick;
    chk("t6_idle_req", bus.upd_req, 0);
    chk("t6_idle_eject", bus.eject, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
